// File: rtl/alu_gen_pkg.sv
// ---------------------------------------------------------------------------
// alu_gen_pkg -- shared definitions for the alu_gen multi-cycle ALU.
//   op_t        : operation codes carried on the 3-bit op input
//   state_t     : controller state encoding
//   booth_sel_t : radix-4 Booth digit selected from three multiplier bits
//   ERR_*       : bit positions and values of the 2-bit ERR output
// ---------------------------------------------------------------------------
package alu_gen_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_XOR = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100,
        OP_MUL = 3'b101,
        OP_DIV = 3'b110,
        OP_RSV = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_CORR = 2'b10,
        S_DONE = 2'b11
    } state_t;

    typedef enum logic [2:0] {
        B_ZERO = 3'd0,
        B_POS1 = 3'd1,
        B_POS2 = 3'd2,
        B_NEG1 = 3'd3,
        B_NEG2 = 3'd4
    } booth_sel_t;

    // ERR = {div_by_zero, overflow_or_illegal}
    localparam int         ERR_DIV0_BIT = 1;
    localparam int         ERR_ILL_BIT  = 0;
    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_DIV0     = 2'(1) << ERR_DIV0_BIT;
    localparam logic [1:0] ERR_ILLEGAL  = 2'(1) << ERR_ILL_BIT;

    // Iteration counter width: wide enough to reach WIDTH without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/alu_gen_if.sv
// ---------------------------------------------------------------------------
// alu_gen_if -- operand/result bundle of alu_gen.
//   X, Y, A_divide, op, BEGIN : request side (driven by the master)
//   OUT, END, BUSY, ERR       : result side (driven by the ALU, slave)
// Parameter WIDTH must match the alu_gen instance it is connected to.
// ---------------------------------------------------------------------------
interface alu_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   X;
    logic [WIDTH-1:0]   Y;
    logic [WIDTH-1:0]   A_divide;
    logic [2:0]         op;
    logic               BEGIN;
    logic [2*WIDTH-1:0] OUT;
    logic               END;
    logic               BUSY;
    logic [1:0]         ERR;

    modport master (
        output X, Y, A_divide, op, BEGIN,
        input  OUT, END, BUSY, ERR
    );

    modport slave (
        input  X, Y, A_divide, op, BEGIN,
        output OUT, END, BUSY, ERR
    );
endinterface

// File: rtl/alu_gen_booth_enc.sv
// ---------------------------------------------------------------------------
// alu_gen_booth_enc -- combinational radix-4 Booth recoder.
//   bits : {q[i+1], q[i], q[i-1]} of the multiplier
//   sel  : selected partial-product digit 0, +1, +2, -1, -2 (times multiplicand)
// ---------------------------------------------------------------------------
module alu_gen_booth_enc
    import alu_gen_pkg::*;
(
    input  logic [2:0]  bits,
    output booth_sel_t  sel
);
    always_comb begin
        sel = B_ZERO;
        case (bits)
            3'b001, 3'b010: sel = B_POS1;
            3'b011:         sel = B_POS2;
            3'b100:         sel = B_NEG2;
            3'b101, 3'b110: sel = B_NEG1;
            default:        sel = B_ZERO;
        endcase
    end
endmodule

// File: rtl/alu_gen.sv
// ---------------------------------------------------------------------------
// alu_gen -- multi-cycle ALU: AND/OR/XOR/ADD/SUB (1 cycle), signed radix-4
// Booth MUL (WIDTH/2 cycles), unsigned non-restoring DIV (WIDTH cycles plus
// one remainder-correction cycle). One WIDTH+2 bit adder/subtractor is shared
// by ADD, SUB, MUL and DIV.
//   clk    : clock, all state on rising edge
//   resetn : asynchronous active-low reset
//   bus    : alu_gen_if.slave (X, Y, A_divide, op, BEGIN / OUT, END, BUSY, ERR)
// WIDTH must be even and >= 4.
// Optional macro ALU_GEN_DEBUG_EN adds dbg_A, dbg_Q, dbg_count, dbg_state
// outputs taken straight from the internal registers.
// ---------------------------------------------------------------------------
module alu_gen
    import alu_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              resetn,
    alu_gen_if.slave          bus
`ifdef ALU_GEN_DEBUG_EN
    ,
    output logic [WIDTH-1:0]        dbg_A,
    output logic [WIDTH-1:0]        dbg_Q,
    output logic [$clog2(WIDTH):0]  dbg_count,
    output logic [1:0]              dbg_state
`endif
);
    localparam int CW = cnt_width(WIDTH);
    localparam int AW = WIDTH + 2;
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    state_t             state_reg;
    op_t                op_reg;
    logic [AW-1:0]      a_reg;      // partial product high / partial remainder
    logic [WIDTH-1:0]   q_reg;      // multiplier / dividend low -> quotient
    logic [WIDTH-1:0]   m_reg;      // multiplicand / divisor
    logic               q1_reg;     // Booth q[-1]
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] out_reg;
    logic [1:0]         err_reg;
    logic               end_reg;
    logic               busy_reg;

    booth_sel_t         booth_sel;
    logic [AW-1:0]      add_a;
    logic [AW-1:0]      add_b;
    logic               add_sub;
    logic [AW-1:0]      sum;
    logic [2*WIDTH-1:0] simple_res;
    logic [WIDTH-1:0]   r_fix;

    alu_gen_booth_enc u_booth (
        .bits ({q_reg[1:0], q1_reg}),
        .sel  (booth_sel)
    );

    // Shared adder/subtractor operand selection.
    always_comb begin
        add_a   = a_reg;
        add_b   = '0;
        add_sub = 1'b0;
        case (op_reg)
            OP_ADD: begin
                add_a = {2'b00, q_reg};
                add_b = {2'b00, m_reg};
            end
            OP_SUB: begin
                add_a   = {{2{q_reg[WIDTH-1]}}, q_reg};
                add_b   = {{2{m_reg[WIDTH-1]}}, m_reg};
                add_sub = 1'b1;
            end
            OP_MUL: begin
                add_a = a_reg;
                case (booth_sel)
                    B_POS1: add_b = {{2{m_reg[WIDTH-1]}}, m_reg};
                    B_NEG1: begin
                        add_b   = {{2{m_reg[WIDTH-1]}}, m_reg};
                        add_sub = 1'b1;
                    end
                    B_POS2: add_b = {m_reg[WIDTH-1], m_reg, 1'b0};
                    B_NEG2: begin
                        add_b   = {m_reg[WIDTH-1], m_reg, 1'b0};
                        add_sub = 1'b1;
                    end
                    default: add_b = '0;
                endcase
            end
            OP_DIV: begin
                add_b = {2'b00, m_reg};
                if (state_reg == S_CORR) begin
                    add_a = a_reg;           // negative remainder: add divisor back
                end else begin
                    // shift {R,Q} left one; subtract when R >= 0, add when R < 0
                    add_a   = {a_reg[AW-2:0], q_reg[WIDTH-1]};
                    add_sub = ~a_reg[AW-1];
                end
            end
            default: ;
        endcase
    end

    assign sum = add_a + (add_sub ? ~add_b : add_b) + {{(AW-1){1'b0}}, add_sub};

    // Results of the single-cycle operations.
    always_comb begin
        simple_res = '0;
        case (op_reg)
            OP_AND:  simple_res = {{WIDTH{1'b0}}, q_reg & m_reg};
            OP_OR:   simple_res = {{WIDTH{1'b0}}, q_reg | m_reg};
            OP_XOR:  simple_res = {{WIDTH{1'b0}}, q_reg ^ m_reg};
            OP_ADD:  simple_res = {{(WIDTH-1){1'b0}}, sum[WIDTH:0]};
            OP_SUB:  simple_res = {{(WIDTH-1){sum[WIDTH]}}, sum[WIDTH:0]};
            default: simple_res = '0;
        endcase
    end

    assign r_fix = a_reg[AW-1] ? sum[WIDTH-1:0] : a_reg[WIDTH-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
            op_reg    <= OP_AND;
            a_reg     <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            q1_reg    <= 1'b0;
            count_reg <= '0;
            out_reg   <= '0;
            err_reg   <= ERR_NONE;
            end_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            end_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.BEGIN) begin
                        op_reg    <= op_t'(bus.op);
                        q_reg     <= bus.X;
                        m_reg     <= bus.Y;
                        a_reg     <= (op_t'(bus.op) == OP_DIV) ? {2'b00, bus.A_divide} : '0;
                        q1_reg    <= 1'b0;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        // Error paths go straight to DONE with their result.
                        if (op_t'(bus.op) == OP_RSV) begin
                            out_reg   <= '0;
                            err_reg   <= ERR_ILLEGAL;
                            end_reg   <= 1'b1;
                            state_reg <= S_DONE;
                        end else if (op_t'(bus.op) == OP_DIV && bus.Y == '0) begin
                            out_reg   <= '1;
                            err_reg   <= ERR_DIV0;
                            end_reg   <= 1'b1;
                            state_reg <= S_DONE;
                        end else if (op_t'(bus.op) == OP_DIV && bus.A_divide >= bus.Y) begin
                            // quotient would not fit in WIDTH bits
                            out_reg   <= '1;
                            err_reg   <= ERR_ILLEGAL;
                            end_reg   <= 1'b1;
                            state_reg <= S_DONE;
                        end else begin
                            state_reg <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    count_reg <= count_reg + 1'b1;
                    case (op_reg)
                        OP_MUL: begin
                            // arithmetic shift right by two of {sum, Q, q-1}
                            a_reg  <= {{2{sum[AW-1]}}, sum[AW-1:2]};
                            q_reg  <= {sum[1:0], q_reg[WIDTH-1:2]};
                            q1_reg <= q_reg[1];
                            if (count_reg == MUL_LAST) begin
                                out_reg   <= {sum, q_reg[WIDTH-1:2]};
                                err_reg   <= ERR_NONE;
                                end_reg   <= 1'b1;
                                state_reg <= S_DONE;
                            end
                        end
                        OP_DIV: begin
                            a_reg <= sum;
                            q_reg <= {q_reg[WIDTH-2:0], ~sum[AW-1]};
                            if (count_reg == DIV_LAST) begin
                                state_reg <= S_CORR;
                            end
                        end
                        default: begin
                            out_reg   <= simple_res;
                            err_reg   <= ERR_NONE;
                            end_reg   <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    endcase
                end
                S_CORR: begin
                    out_reg   <= {r_fix, q_reg};
                    err_reg   <= ERR_NONE;
                    end_reg   <= 1'b1;
                    state_reg <= S_DONE;
                end
                S_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.OUT  = out_reg;
    assign bus.END  = end_reg;
    assign bus.BUSY = busy_reg;
    assign bus.ERR  = err_reg;

`ifdef ALU_GEN_DEBUG_EN
    assign dbg_A     = a_reg[WIDTH-1:0];
    assign dbg_Q     = q_reg;
    assign dbg_count = count_reg;
    assign dbg_state = state_reg;
`endif

endmodule

// File: tb/tb_alu_gen.sv
// ---------------------------------------------------------------------------
// tb_alu_gen -- self-checking bench for alu_gen (WIDTH=8 and WIDTH=16).
// Latency is reported as the number of rising edges from the BEGIN capture
// edge k to the edge at which END is sampled high (AND = 2, MUL8 = 5, ...).
// ---------------------------------------------------------------------------
module tb_alu_gen;
    import alu_gen_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    alu_gen_if #(.WIDTH(8))  b8();
    alu_gen_if #(.WIDTH(16)) b16();

    alu_gen #(.WIDTH(8))  dut8  (.clk(clk), .resetn(resetn), .bus(b8));
    alu_gen #(.WIDTH(16)) dut16 (.clk(clk), .resetn(resetn), .bus(b16));

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  ad;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] out;
        logic [1:0]  err;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic run8(input vec_t v, output logic [15:0] out, output logic [1:0] err,
                        output int lat);
        b8.op = v.op; b8.A_divide = v.ad; b8.X = v.x; b8.Y = v.y; b8.BEGIN = 1'b1;
        @(posedge clk);                    // capture edge k
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            b8.BEGIN = 1'b0;
            // inputs must not be looked at after capture
            b8.X = 8'($urandom); b8.Y = 8'($urandom);
            b8.A_divide = 8'($urandom); b8.op = 3'($urandom);
            if (b8.END === 1'b1) lat = c;
            else @(posedge clk);
        end
        out = b8.OUT;
        err = b8.ERR;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] out;
        logic [1:0]  err;
        int          lat;
        logic [31:0] out16;
        logic [1:0]  err16;
        bit          saw_end;

        b8.BEGIN = 0; b8.op = 0; b8.X = 0; b8.Y = 0; b8.A_divide = 0;
        b16.BEGIN = 0; b16.op = 0; b16.X = 0; b16.Y = 0; b16.A_divide = 0;

        //            op      A_div  X      Y      OUT        ERR    lat
        vecs[0]  = '{OP_AND, 8'h00, 8'hF0, 8'h3C, 16'h0030, 2'b00, 2};
        vecs[1]  = '{OP_OR,  8'h00, 8'hA0, 8'h05, 16'h00A5, 2'b00, 2};
        vecs[2]  = '{OP_XOR, 8'h00, 8'h11, 8'h05, 16'h0014, 2'b00, 2};
        vecs[3]  = '{OP_ADD, 8'h00, 8'hFF, 8'h01, 16'h0100, 2'b00, 2};
        vecs[4]  = '{OP_ADD, 8'h00, 8'h7F, 8'h80, 16'h00FF, 2'b00, 2};
        vecs[5]  = '{OP_SUB, 8'h00, 8'h05, 8'h11, 16'hFFF4, 2'b00, 2};
        vecs[6]  = '{OP_SUB, 8'h00, 8'h80, 8'h7F, 16'hFF01, 2'b00, 2};
        vecs[7]  = '{OP_MUL, 8'h00, 8'hB9, 8'h85, 16'h221D, 2'b00, 5};
        vecs[8]  = '{OP_MUL, 8'h00, 8'h80, 8'h80, 16'h4000, 2'b00, 5};
        vecs[9]  = '{OP_MUL, 8'h00, 8'h7F, 8'h80, 16'hC080, 2'b00, 5};
        vecs[10] = '{OP_MUL, 8'h00, 8'h03, 8'hFB, 16'hFFF1, 2'b00, 5};
        vecs[11] = '{OP_DIV, 8'h16, 8'h8B, 8'h87, 16'h652A, 2'b00, 10};
        vecs[12] = '{OP_DIV, 8'h00, 8'hFF, 8'h10, 16'h0F0F, 2'b00, 10};
        vecs[13] = '{OP_DIV, 8'h12, 8'h34, 8'h00, 16'hFFFF, 2'b10, 1};
        vecs[14] = '{OP_DIV, 8'h90, 8'h00, 8'h87, 16'hFFFF, 2'b01, 1};
        vecs[15] = '{OP_RSV, 8'h55, 8'h66, 8'h77, 16'h0000, 2'b01, 1};
        vecs[16] = '{OP_DIV, 8'h87, 8'h01, 8'h87, 16'hFFFF, 2'b01, 1};
        vecs[17] = '{OP_DIV, 8'h86, 8'hFF, 8'h87, 16'h86FF, 2'b00, 10};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_out",  32'(b8.OUT),  32'h0);
        check("rst_end",  32'(b8.END),  32'h0);
        check("rst_busy", 32'(b8.BUSY), 32'h0);
        check("rst_err",  32'(b8.ERR),  32'h0);

        // first BEGIN rides on the first rising edge with resetn high
        resetn = 1'b1;
        for (int i = 0; i < NV; i++) begin
            run8(vecs[i], out, err, lat);
            $display("vec %0d op=%0d A=%h X=%h Y=%h -> OUT=%h ERR=%b lat=%0d",
                     i, vecs[i].op, vecs[i].ad, vecs[i].x, vecs[i].y, out, err, lat);
            check($sformatf("v%0d_out", i), 32'(out), 32'(vecs[i].out));
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_hold", i), 32'(b8.OUT), 32'(vecs[i].out));
        end

        // reset in the middle of a multiply
        b8.op = OP_MUL; b8.X = 8'hB9; b8.Y = 8'h85; b8.A_divide = 8'h00; b8.BEGIN = 1'b1;
        @(posedge clk);                    // k
        @(negedge clk); b8.BEGIN = 1'b0;
        @(posedge clk);                    // k+1
        @(negedge clk);
        check("mid_busy", 32'(b8.BUSY), 32'h1);
        resetn = 1'b0;
        #1;
        check("mr_busy", 32'(b8.BUSY), 32'h0);
        check("mr_out",  32'(b8.OUT),  32'h0);
        check("mr_end",  32'(b8.END),  32'h0);
        check("mr_err",  32'(b8.ERR),  32'h0);
        $display("reset mid-MUL: OUT=%h BUSY=%b END=%b", b8.OUT, b8.BUSY, b8.END);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        saw_end = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (b8.END === 1'b1) saw_end = 1'b1;
        end
        check("mr_no_end", 32'(saw_end), 32'h0);
        run8(vecs[7], out, err, lat);
        $display("after reset MUL -> OUT=%h ERR=%b lat=%0d", out, err, lat);
        check("mr2_out", 32'(out), 32'h221D);
        check("mr2_err", 32'(err), 32'h0);
        check("mr2_lat", 32'(lat), 32'd5);

        // WIDTH=16 divide with BEGIN held high while busy
        b16.op = OP_DIV; b16.A_divide = 16'h0001; b16.X = 16'h0000; b16.Y = 16'h0003;
        b16.BEGIN = 1'b1;
        @(posedge clk);                    // capture edge k
        lat = 0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            b16.X = 16'($urandom); b16.Y = 16'($urandom); b16.A_divide = 16'($urandom);
            if (b16.END === 1'b1) lat = c;
            else @(posedge clk);
        end
        out16 = b16.OUT;
        err16 = b16.ERR;
        b16.BEGIN = 1'b0;
        $display("div16 {0001,0000}/0003 -> OUT=%h ERR=%b lat=%0d", out16, err16, lat);
        check("d16_out", out16, 32'h0001_5555);
        check("d16_err", 32'(err16), 32'h0);
        check("d16_lat", 32'(lat), 32'd18);
        @(negedge clk);
        check("d16_idle", 32'(b16.BUSY), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
